// File: rtl/race_key_ctrl.sv
// Keyboard-to-race-event mapper: tracks held game keys, suppresses typematic
// repeats, detects releases and queues 3-bit events in a 4-deep FIFO.
module race_key_ctrl (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       code_new,
    input  logic       key_pressed,
    input  logic [7:0] key_code,
    input  logic       race_active,
    output logic       ev_valid,
    output logic [2:0] ev_code,
    input  logic       ev_ready,
    output logic [3:0] held,
    output logic       ovf,
    input  logic       clr_ovf
);

    localparam logic [7:0] P1_THR    = 8'h1D;
    localparam logic [7:0] P1_SHF    = 8'h23;
    localparam logic [7:0] P2_THR    = 8'h43;
    localparam logic [7:0] P2_SHF    = 8'h4B;
    localparam logic [7:0] START_KEY = 8'h29;
    localparam logic [7:0] ABORT_KEY = 8'h76;

    localparam logic [2:0] EV_P1_THR_ON  = 3'd0;
    localparam logic [2:0] EV_P1_THR_OFF = 3'd1;
    localparam logic [2:0] EV_P1_SHIFT   = 3'd2;
    localparam logic [2:0] EV_P2_THR_ON  = 3'd3;
    localparam logic [2:0] EV_P2_THR_OFF = 3'd4;
    localparam logic [2:0] EV_P2_SHIFT   = 3'd5;
    localparam logic [2:0] EV_START      = 3'd6;
    localparam logic [2:0] EV_ABORT      = 3'd7;

    logic       kp_q, kp_d;
    logic [7:0] kc_q, kc_d;
    logic       race_q, race_d;
    logic [3:0] held_q, held_d;
    logic       ovf_q, ovf_d;
    logic [1:0] wr_q, wr_d;
    logic [1:0] rd_q, rd_d;
    logic [2:0] cnt_q, cnt_d;
    logic [2:0] mem_q [4];
    logic [2:0] mem_d [4];

    logic       is_make;
    logic       is_brk;
    logic       race_fall;
    logic       map_hit;
    logic [1:0] map_idx;
    logic       push;
    logic [2:0] push_code;
    logic       pop;
    logic       full;
    logic       accept;
    logic       drop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kp_q   <= 1'b0;
            kc_q   <= 8'h00;
            race_q <= 1'b0;
            held_q <= 4'b0000;
            ovf_q  <= 1'b0;
            wr_q   <= 2'd0;
            rd_q   <= 2'd0;
            cnt_q  <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= 3'd0;
            end
        end else begin
            kp_q   <= kp_d;
            kc_q   <= kc_d;
            race_q <= race_d;
            held_q <= held_d;
            ovf_q  <= ovf_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // A break is a falling key_pressed, or a new code arriving while released.
    always_comb begin
        kp_d      = key_pressed;
        kc_d      = key_code;
        race_d    = race_active;
        is_make   = code_new;
        is_brk    = !code_new && !key_pressed && (kp_q || (key_code != kc_q));
        race_fall = race_q && !race_active;
    end

    always_comb begin
        map_hit = 1'b1;
        map_idx = 2'd0;
        case (key_code)
            P1_THR:  map_idx = 2'd0;
            P1_SHF:  map_idx = 2'd1;
            P2_THR:  map_idx = 2'd2;
            P2_SHF:  map_idx = 2'd3;
            default: map_hit = 1'b0;
        endcase
    end

    always_comb begin
        held_d    = held_q;
        push      = 1'b0;
        push_code = 3'd0;
        if (race_fall) begin
            held_d = 4'b0000;
        end else if (map_hit && is_make && !held_q[map_idx]) begin
            held_d[map_idx] = 1'b1;
            push            = race_active;
            case (map_idx)
                2'd0:    push_code = EV_P1_THR_ON;
                2'd1:    push_code = EV_P1_SHIFT;
                2'd2:    push_code = EV_P2_THR_ON;
                default: push_code = EV_P2_SHIFT;
            endcase
        end else if (map_hit && is_brk) begin
            held_d[map_idx] = 1'b0;
            // Shift releases are silent; throttle releases only if it was held.
            push      = held_q[map_idx] && !map_idx[0];
            push_code = map_idx[1] ? EV_P2_THR_OFF : EV_P1_THR_OFF;
        end
        if (is_make && (key_code == START_KEY) && !race_active) begin
            push      = 1'b1;
            push_code = EV_START;
        end
        if (is_make && (key_code == ABORT_KEY)) begin
            push      = 1'b1;
            push_code = EV_ABORT;
        end
    end

    // Pop frees a slot in the same cycle, so a full FIFO still accepts.
    always_comb begin
        pop    = (cnt_q != 3'd0) && ev_ready;
        full   = (cnt_q == 3'd4);
        accept = push && (!full || pop);
        drop   = push && full && !pop;
        wr_d   = accept ? wr_q + 2'd1 : wr_q;
        rd_d   = pop ? rd_q + 2'd1 : rd_q;
        cnt_d  = cnt_q + {2'b00, accept} - {2'b00, pop};
        for (int i = 0; i < 4; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (accept) begin
            mem_d[wr_q] = push_code;
        end
        ovf_d = ovf_q;
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        ev_valid = (cnt_q != 3'd0);
        ev_code  = ev_valid ? mem_q[rd_q] : 3'd0;
        held     = held_q;
        ovf      = ovf_q;
    end

endmodule
